// File: rtl/floo_pkg.sv
// Shared FlooNoC chimney definitions.
// IdxRoB selects the index-addressed reorder buffer on response paths.
package floo_pkg;

   typedef enum logic [1:0] {
      NoRoB,
      NormalRoB,
      SimpleRoB,
      IdxRoB
   } rob_type_e;

endpackage

// File: rtl/floo_rob_mem.sv
// Reorder-buffer payload storage: NumEntries x DataWidth, one write port and one
// combinational read port. Kept standalone so it can be swapped for an SRAM macro.
module floo_rob_mem #(
   parameter int unsigned NumEntries = 64,
   parameter int unsigned DataWidth  = 32,
   parameter int unsigned IdxWidth   = $clog2(NumEntries)
) (
   input  logic                 clk_i,
   input  logic                 we_i,
   input  logic [IdxWidth-1:0]  waddr_i,
   input  logic [DataWidth-1:0] wdata_i,
   input  logic [IdxWidth-1:0]  raddr_i,
   output logic [DataWidth-1:0] rdata_o
);

   logic [DataWidth-1:0] mem_q [NumEntries];

   // Payload is never reset; validity lives in the control bit vectors.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/floo_idx_rob.sv
// Index-addressed reorder buffer: slots are allocated in order, filled out of order
// by rob_idx, and released strictly in allocation order.
module floo_idx_rob
   import floo_pkg::*;
#(
   parameter int unsigned NumEntries  = 64,
   parameter int unsigned DataWidth   = 32,
   parameter bit          FallThrough = 1'b0,
   parameter int unsigned IdxWidth    = $clog2(NumEntries)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 alloc_valid_i,
   output logic                 alloc_ready_o,
   output logic [IdxWidth-1:0]  alloc_idx_o,
   input  logic                 rsp_valid_i,
   output logic                 rsp_ready_o,
   input  logic [IdxWidth-1:0]  rsp_idx_i,
   input  logic [DataWidth-1:0] rsp_data_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [IdxWidth-1:0]  out_idx_o,
   output logic [DataWidth-1:0] out_data_o,
   output logic [IdxWidth:0]    occupancy_o,
   output logic                 full_o,
   output logic                 empty_o,
   output logic                 err_o
);

   localparam logic [IdxWidth:0] FullCount = (IdxWidth+1)'(NumEntries);

   logic [IdxWidth:0]     alloc_ptr_q, alloc_ptr_d;
   logic [IdxWidth:0]     release_ptr_q, release_ptr_d;
   logic [NumEntries-1:0] alloc_q, alloc_d;
   logic [NumEntries-1:0] filled_q, filled_d;
   logic                  err_q, err_d;

   logic [IdxWidth-1:0]  head;
   logic [DataWidth-1:0] mem_rdata;
   logic                 alloc_fire;
   logic                 rsp_legal;
   logic                 rsp_to_head;
   logic                 release_fire;

   assign head        = release_ptr_q[IdxWidth-1:0];
   assign occupancy_o = alloc_ptr_q - release_ptr_q;
   assign full_o      = (occupancy_o == FullCount);
   assign empty_o     = (occupancy_o == '0);
   assign err_o       = err_q;

   assign alloc_ready_o = !full_o;
   assign alloc_idx_o   = alloc_ptr_q[IdxWidth-1:0];
   assign alloc_fire    = alloc_valid_i && alloc_ready_o;

   // A response is only legal for an allocated slot that has not been written yet.
   assign rsp_ready_o = 1'b1;
   assign rsp_legal   = rsp_valid_i && alloc_q[rsp_idx_i] && !filled_q[rsp_idx_i];
   assign rsp_to_head = rsp_legal && (rsp_idx_i == head);

   always_comb begin
      out_valid_o = filled_q[head];
      out_data_o  = mem_rdata;
      if (FallThrough && rsp_to_head) begin
         out_valid_o = 1'b1;
         out_data_o  = rsp_data_i;
      end
   end

   assign out_idx_o    = head;
   assign release_fire = out_valid_o && out_ready_i;

   always_comb begin
      alloc_ptr_d   = alloc_ptr_q;
      release_ptr_d = release_ptr_q;
      alloc_d       = alloc_q;
      filled_d      = filled_q;
      err_d         = err_q;
      if (alloc_fire) begin
         alloc_d[alloc_idx_o] = 1'b1;
         alloc_ptr_d          = alloc_ptr_q + 1'b1;
      end
      if (rsp_legal) begin
         filled_d[rsp_idx_i] = 1'b1;
      end else if (rsp_valid_i) begin
         err_d = 1'b1;
      end
      // Release clears after the write so a fall-through response leaves no residue.
      if (release_fire) begin
         alloc_d[head]  = 1'b0;
         filled_d[head] = 1'b0;
         release_ptr_d  = release_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         alloc_ptr_q   <= '0;
         release_ptr_q <= '0;
         alloc_q       <= '0;
         filled_q      <= '0;
         err_q         <= 1'b0;
      end else begin
         alloc_ptr_q   <= alloc_ptr_d;
         release_ptr_q <= release_ptr_d;
         alloc_q       <= alloc_d;
         filled_q      <= filled_d;
         err_q         <= err_d;
      end
   end

   floo_rob_mem #(
      .NumEntries (NumEntries),
      .DataWidth  (DataWidth),
      .IdxWidth   (IdxWidth)
   ) u_mem (
      .clk_i   (clk_i),
      .we_i    (rsp_legal),
      .waddr_i (rsp_idx_i),
      .wdata_i (rsp_data_i),
      .raddr_i (head),
      .rdata_o (mem_rdata)
   );

endmodule
